uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among NUM_REQ byte-stream requesters (cores, debug, DMA).
//  - Arbitration is round-robin at line granularity.
//  - A granted requester keeps the transmitter until it sends EOL_CHAR, or until it

---
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, line-granular arbiter that shares one UART TX byte stream among NUM_REQ requesters.
// The owner is locked until it sends EOL_CHAR or idles for LOCK_TIMEOUT cycles; data path is combinational.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter logic [7:0]  EOL_CHAR     = 8'h0A
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic [IW-1:0]      pick;
  logic               pick_vld;
  logic [IW-1:0]      cand;
  int                 idx;
  logic               xfer;

  // Scan starts just after the previous owner so every requester gets a turn per round.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    idx      = 0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx  = (int'(last_q) + k) % int'(NUM_REQ);
      cand = IW'(idx);
      if (!pick_vld && req_valid_i[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    req_ready_o = '0;
    xfer        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d       = LOCKED;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          cnt_d         = '0;
        end
      end
      LOCKED: begin
        tx_valid_o           = req_valid_i[owner_q];
        tx_data_o            = tx_valid_o ? req_data_i[{owner_q, 3'b000} +: 8] : 8'h00;
        req_ready_o[owner_q] = tx_ready_i;
        xfer                 = tx_valid_o & tx_ready_i;
        if (xfer) begin
          cnt_d = '0;
          if (tx_data_o == EOL_CHAR) begin
            state_d = IDLE;
            last_d  = owner_q;
            grant_d = '0;
          end
        end else if (!req_valid_i[owner_q]) begin
          // Only an idle owner ages the lock; a stalled sink never forces release.
          if (cnt_q == CNT_MAX) begin
            state_d   = IDLE;
            last_d    = owner_q;
            grant_d   = '0;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      grant_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state_q == LOCKED);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle vectors for reset and pass-through, then queued requester
// streams checked against an expected-byte scoreboard for ordering, timeout and reset cases.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready = 1'b0;
  logic [3:0]  grant_o;
  logic        busy_o;
  logic        timeout_o;

  always #5 clk = clk_en ? ~clk : clk;

  uart_tx_arbiter #(.NUM_REQ(4), .LOCK_TIMEOUT(16), .EOL_CHAR(8'h0A)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready),
    .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] dat;
    logic        rdy;
    logic [3:0]  gnt;
    logic        busy;
    logic        txv;
    logic [7:0]  txd;
    logic [3:0]  rr;
    logic        to;
  } vec_t;

  typedef struct {
    logic [7:0] dat;
    logic [3:0] gnt;
  } exp_t;

  vec_t        tbl [10];
  exp_t        sb [$];
  logic [7:0]  rq [4][$];
  logic [3:0]  acc = '0;
  logic [3:0]  tbl_vld = '0;
  logic [31:0] tbl_dat = '0;
  logic        rdy_set = 1'b0;
  logic        model_on = 1'b0;
  logic        sb_on = 1'b0;
  logic        gap_chk = 1'b0;
  logic        have_prev = 1'b0;
  int          prev_cyc = 0;
  int          cyc = 0;
  int          last_xfer_cyc = 0;
  int          n_xfer = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_b(input logic [7:0] b, input logic [3:0] g);
    exp_t e;
    e.dat = b;
    e.gnt = g;
    sb.push_back(e);
  endtask

  // One clock: drive inputs just after the edge, then sample and score at the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    if (model_on) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[i]       = (rq[i].size() > 0);
        req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
      end
    end else begin
      req_valid = tbl_vld;
      req_data  = tbl_dat;
    end
    tx_ready = rdy_set;
    @(negedge clk);
    cyc++;
    acc = req_valid & req_ready_o;
    if (sb_on && tx_valid_o && tx_ready) begin
      n_xfer++;
      last_xfer_cyc = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_extra: got byte %h from grant %b, expected no transfer", tx_data_o, grant_o);
      end else begin
        e = sb.pop_front();
        chk("sb_byte", {tx_data_o, grant_o}, {e.dat, e.gnt});
      end
      if (gap_chk) begin
        if (have_prev) chk("t3_gap", cyc - prev_cyc, 2);
        prev_cyc  = cyc;
        have_prev = 1'b1;
      end
    end
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk(nm, sb.size(), 0);
  endtask

  // Entered at a falling edge; asserts reset between edges and checks outputs clear at once.
  task automatic do_reset(input string nm);
    #2 rst_n = 1'b0;
    #1;
    chk(nm, {grant_o, busy_o, tx_valid_o, req_ready_o, timeout_o}, '0);
    for (int i = 0; i < 4; i++) rq[i].delete();
    sb.delete();
    acc       = '0;
    req_valid = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    int to_cyc;
    int k;
    int x0;

    tbl[0] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[1] = '{4'b1001, 32'h5A000041, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[2] = '{4'b1001, 32'h5A000041, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h41, 4'b0001, 1'b0};
    tbl[3] = '{4'b1001, 32'h5A00000A, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h0A, 4'b0000, 1'b0};
    tbl[4] = '{4'b1001, 32'h5A00000A, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h0A, 4'b0001, 1'b0};
    tbl[5] = '{4'b1001, 32'h5A000042, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[6] = '{4'b1001, 32'h5A000042, 1'b1, 4'b1000, 1'b1, 1'b1, 8'h5A, 4'b1000, 1'b0};
    tbl[7] = '{4'b0001, 32'h00000042, 1'b1, 4'b1000, 1'b1, 1'b0, 8'h00, 4'b1000, 1'b0};
    tbl[8] = '{4'b1001, 32'h0A000042, 1'b1, 4'b1000, 1'b1, 1'b1, 8'h0A, 4'b1000, 1'b0};
    tbl[9] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};

    // Reset with the clock stopped must clear outputs immediately.
    #3 rst_n = 1'b0;
    #1;
    chk("t1_rst", {grant_o, busy_o, tx_valid_o, req_ready_o, timeout_o}, '0);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tbl_vld = tbl[i].vld;
      tbl_dat = tbl[i].dat;
      rdy_set = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d", i),
          {grant_o, busy_o, tx_valid_o, tx_data_o, req_ready_o, timeout_o},
          {tbl[i].gnt, tbl[i].busy, tbl[i].txv, tbl[i].txd, tbl[i].rr, tbl[i].to});
    end

    // Two lines offered together come out whole, owner 0 first.
    model_on = 1'b1;
    sb_on    = 1'b1;
    rdy_set  = 1'b1;
    rq[0].push_back(8'h41); rq[0].push_back(8'h42); rq[0].push_back(8'h0A);
    rq[2].push_back(8'h43); rq[2].push_back(8'h44); rq[2].push_back(8'h0A);
    expect_b(8'h41, 4'b0001); expect_b(8'h42, 4'b0001); expect_b(8'h0A, 4'b0001);
    expect_b(8'h43, 4'b0100); expect_b(8'h44, 4'b0100); expect_b(8'h0A, 4'b0100);
    wait_drain("t2_drain", 30);

    // Single-byte lines rotate 0,1,2,3,0,1 with one idle cycle between owners.
    do_reset("t3_rst");
    rq[0].push_back(8'h0A); rq[0].push_back(8'h0A);
    rq[1].push_back(8'h0A); rq[1].push_back(8'h0A);
    rq[2].push_back(8'h0A);
    rq[3].push_back(8'h0A);
    expect_b(8'h0A, 4'b0001); expect_b(8'h0A, 4'b0010);
    expect_b(8'h0A, 4'b0100); expect_b(8'h0A, 4'b1000);
    expect_b(8'h0A, 4'b0001); expect_b(8'h0A, 4'b0010);
    gap_chk   = 1'b1;
    have_prev = 1'b0;
    wait_drain("t3_drain", 30);
    gap_chk = 1'b0;

    // Owner goes quiet after one byte: forced release after 16 idle cycles.
    do_reset("t4_rst");
    rq[1].push_back(8'h58);
    expect_b(8'h58, 4'b0010);
    wait_drain("t4_x", 20);
    n0 = last_xfer_cyc;
    rq[3].push_back(8'h5A); rq[3].push_back(8'h0A);
    expect_b(8'h5A, 4'b1000); expect_b(8'h0A, 4'b1000);
    to_cyc = -1;
    k = 0;
    while (to_cyc < 0 && k < 40) begin
      tick();
      if (timeout_o) to_cyc = cyc;
      k++;
    end
    chk("t4_to_cyc", to_cyc, n0 + 17);
    tick();
    chk("t4_after", {grant_o, timeout_o}, {4'b1000, 1'b0});
    wait_drain("t4_z", 20);

    // Sink backpressure for 40 cycles must neither time out nor lose/duplicate the byte.
    rdy_set = 1'b0;
    rq[0].push_back(8'h51); rq[0].push_back(8'h0A);
    expect_b(8'h51, 4'b0001); expect_b(8'h0A, 4'b0001);
    k = 0;
    while (grant_o != 4'b0001 && k < 5) begin
      tick();
      k++;
    end
    chk("t5_grant", grant_o, 4'b0001);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("t5_hold", {timeout_o, req_ready_o, tx_valid_o, busy_o, tx_data_o},
          {1'b0, 4'b0000, 1'b1, 1'b1, 8'h51});
    end
    x0 = n_xfer;
    rdy_set = 1'b1;
    wait_drain("t5_drain", 10);
    repeat (4) tick();
    chk("t5_count", n_xfer - x0, 2);

    // Reset in the middle of a line, then lowest valid index wins.
    do_reset("t6_rst0");
    rq[2].push_back(8'h41); rq[2].push_back(8'h42); rq[2].push_back(8'h0A);
    expect_b(8'h41, 4'b0100);
    wait_drain("t6_a", 10);
    rdy_set = 1'b0;
    tick();
    chk("t6_pre", {grant_o, busy_o, tx_valid_o, tx_data_o}, {4'b0100, 1'b1, 1'b1, 8'h42});
    do_reset("t6_rst");
    rdy_set = 1'b1;
    rq[2].push_back(8'h43); rq[2].push_back(8'h0A);
    rq[1].push_back(8'h44); rq[1].push_back(8'h0A);
    expect_b(8'h44, 4'b0010); expect_b(8'h0A, 4'b0010);
    expect_b(8'h43, 4'b0100); expect_b(8'h0A, 4'b0100);
    wait_drain("t6_drain", 20);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
